assoc_kv_store: RTL and testbench

Synthesizable key/value store that gives hardware the semantics of a SystemVerilog associative array: write a value under a key, look a key up, delete a key, or clear the store. Commands arrive over a valid/ready handshake and results leave over a second handshake. Lookup of a missing key returns hit=0 and value 0, which is the 2-state default. The block is the storage stage behind the associative-array examples, so testbench stimulus can be mirrored in RTL.

---
 rtl/assoc_kv_store.sv | 199 +++++++++++++++++++
 tb/tb_assoc_kv_store.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/assoc_kv_store.sv
// Associative key/value store: lookup, write, delete and clear over a
// valid/ready command channel, with results returned on a valid/ready
// response channel. Each command is resolved by a linear scan of all entries.

// One storage slot: valid flag plus key/value payload.
module kv_entry #(
    parameter int KEY_W = 32,
    parameter int VAL_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_en,
    input  logic             del_en,
    input  logic [KEY_W-1:0] wr_key,
    input  logic [VAL_W-1:0] wr_val,
    output logic             valid,
    output logic [KEY_W-1:0] key,
    output logic [VAL_W-1:0] val
);

    // Valid flag: reset and clear dominate, then insert/overwrite, then delete.
    always_ff @(posedge clk) begin
        if (rst || clr)  valid <= 1'b0;
        else if (wr_en)  valid <= 1'b1;
        else if (del_en) valid <= 1'b0;
    end

    // Payload needs no reset; it is only observed while valid is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            key <= wr_key;
            val <= wr_val;
        end
    end

endmodule

module assoc_kv_store #(
    parameter int KEY_W = 32,
    parameter int VAL_W = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [KEY_W-1:0]           cmd_key,
    input  logic [VAL_W-1:0]           cmd_val,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic                       rsp_hit,
    output logic [VAL_W-1:0]           rsp_val,
    output logic                       rsp_full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    // Opcodes; 2'b00 is lookup, which needs no table update.
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_DELETE = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

    typedef struct packed {
        logic [1:0]       op;
        logic [KEY_W-1:0] key;
        logic [VAL_W-1:0] val;
    } cmd_t;

    typedef struct packed {
        logic             hit;
        logic [VAL_W-1:0] val;
        logic             full;
    } rsp_t;

    state_t state, state_nxt;
    cmd_t   cmd_q;
    rsp_t   rsp_q;

    logic [IDX_W-1:0] idx;
    logic             hit_q, free_q;
    logic [IDX_W-1:0] hit_idx_q, free_idx_q;

    logic                         cmd_fire;
    logic [DEPTH-1:0]             ent_valid;
    logic [DEPTH-1:0][KEY_W-1:0]  ent_key;
    logic [DEPTH-1:0][VAL_W-1:0]  ent_val;

    logic             match_now;
    logic             hit_fin, free_fin;
    logic [IDX_W-1:0] hit_idx_fin, free_idx_fin, wr_slot;
    logic             scan_done;
    logic             do_write, do_insert, do_delete, do_clear;

    // Handshake qualifiers; cmd_ready is held low while reset is asserted.
    assign cmd_ready = (state == IDLE) && !rst;
    assign rsp_valid = (state == RESP);
    assign cmd_fire  = cmd_valid && cmd_ready;

    assign rsp_hit  = rsp_q.hit;
    assign rsp_val  = rsp_q.val;
    assign rsp_full = rsp_q.full;

    // Storage slots; each gets its own write/delete strobe from the scan result.
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        kv_entry #(.KEY_W(KEY_W), .VAL_W(VAL_W)) u_ent (
            .clk    (clk),
            .rst    (rst),
            .clr    (do_clear),
            .wr_en  (do_write  && (wr_slot     == IDX_W'(i))),
            .del_en (do_delete && (hit_idx_fin == IDX_W'(i))),
            .wr_key (cmd_q.key),
            .wr_val (cmd_q.val),
            .valid  (ent_valid[i]),
            .key    (ent_key[i]),
            .val    (ent_val[i])
        );
    end

    // Fold the current slot into the running scan result; lowest index wins
    // for both match and free slot because earlier hits are kept.
    always_comb begin
        match_now    = ent_valid[idx] && (ent_key[idx] == cmd_q.key);
        hit_fin      = hit_q || match_now;
        hit_idx_fin  = hit_q ? hit_idx_q : idx;
        free_fin     = free_q || !ent_valid[idx];
        free_idx_fin = free_q ? free_idx_q : idx;
        scan_done    = (state == SCAN) && (idx == IDX_W'(DEPTH-1));
        do_write     = scan_done && (cmd_q.op == OP_WRITE) && (hit_fin || free_fin);
        do_insert    = do_write && !hit_fin;
        do_delete    = scan_done && (cmd_q.op == OP_DELETE) && hit_fin;
        do_clear     = cmd_fire && (cmd_op == OP_CLEAR);
        wr_slot      = hit_fin ? hit_idx_fin : free_idx_fin;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state: clear completes on accept, everything else walks the table.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_fire)  state_nxt = (cmd_op == OP_CLEAR) ? RESP : SCAN;
            SCAN:    if (scan_done) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Command latch and scan bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q      <= '0;
            idx        <= '0;
            hit_q      <= 1'b0;
            free_q     <= 1'b0;
            hit_idx_q  <= '0;
            free_idx_q <= '0;
        end else if (cmd_fire) begin
            cmd_q  <= '{op: cmd_op, key: cmd_key, val: cmd_val};
            idx    <= '0;
            hit_q  <= 1'b0;
            free_q <= 1'b0;
        end else if (state == SCAN) begin
            if (!scan_done) idx <= idx + IDX_W'(1);
            hit_q      <= hit_fin;
            hit_idx_q  <= hit_idx_fin;
            free_q     <= free_fin;
            free_idx_q <= free_idx_fin;
        end
    end

    // Response and occupancy update on the edge that enters RESP; both hold
    // steady through backpressure because nothing else writes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_q <= '0;
            count <= '0;
        end else if (do_clear) begin
            rsp_q <= '0;
            count <= '0;
        end else if (scan_done) begin
            rsp_q.hit  <= hit_fin;
            rsp_q.val  <= hit_fin ? ent_val[hit_idx_fin] : '0;
            rsp_q.full <= (cmd_q.op == OP_WRITE) && !hit_fin && !free_fin;
            if (do_insert)      count <= count + CNT_W'(1);
            else if (do_delete) count <= count - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_assoc_kv_store.sv
// Directed bench for assoc_kv_store: each step drives one command and
// compares latency, response fields and occupancy against hand-computed values.
module tb_assoc_kv_store;

    localparam int KEY_W = 40;
    localparam int VAL_W = 32;
    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    localparam logic [1:0] LOOKUP = 2'b00;
    localparam logic [1:0] WRITE  = 2'b01;
    localparam logic [1:0] DELETE = 2'b10;
    localparam logic [1:0] CLEAR  = 2'b11;

    localparam logic [KEY_W-1:0] K_RAM   = 40'h00_0072_616D;
    localparam logic [KEY_W-1:0] K_SITA  = 40'h00_7369_7461;
    localparam logic [KEY_W-1:0] K_KAMAL = 40'h6B_616D_616C;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [KEY_W-1:0] cmd_key = '0;
    logic [VAL_W-1:0] cmd_val = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic             rsp_hit;
    logic [VAL_W-1:0] rsp_val;
    logic             rsp_full;
    logic [CNT_W-1:0] count;

    int n_vec = 0;
    int n_err = 0;

    int               r_lat, r_wait;
    logic             r_hit, r_full;
    logic [VAL_W-1:0] r_val;
    logic [CNT_W-1:0] r_cnt;
    logic             seen;

    assoc_kv_store #(.KEY_W(KEY_W), .VAL_W(VAL_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_key   (cmd_key),
        .cmd_val   (cmd_val),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_hit   (rsp_hit),
        .rsp_val   (rsp_val),
        .rsp_full  (rsp_full),
        .count     (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Count negedges from the accept edge until rsp_valid, then capture outputs.
    task automatic wait_rsp();
        r_lat = 1;
        while (!rsp_valid && r_lat < 40) begin
            @(negedge clk);
            r_lat++;
        end
        r_hit  = rsp_hit;
        r_val  = rsp_val;
        r_full = rsp_full;
        r_cnt  = count;
    endtask

    // Present a command from a negedge, wait (bounded) for acceptance, then for the response.
    task automatic send(input logic [1:0] op, input logic [KEY_W-1:0] k, input logic [VAL_W-1:0] v);
        cmd_op    = op;
        cmd_key   = k;
        cmd_val   = v;
        cmd_valid = 1'b1;
        #1;
        r_wait = 0;
        while (!cmd_ready && r_wait < 40) begin
            @(negedge clk);
            #1;
            r_wait++;
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_rsp();
    endtask

    // Consume the pending response (rsp_ready is high) and land back in IDLE.
    task automatic take();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic op_chk(input string tag, input logic [1:0] op, input logic [KEY_W-1:0] k,
                          input logic [VAL_W-1:0] v, input int e_lat, input logic e_hit,
                          input logic [VAL_W-1:0] e_val, input logic e_full, input int e_cnt);
        send(op, k, v);
        chk({tag, ".lat"},  64'(r_lat),  64'(e_lat));
        chk({tag, ".hit"},  64'(r_hit),  64'(e_hit));
        chk({tag, ".val"},  64'(r_val),  64'(e_val));
        chk({tag, ".full"}, 64'(r_full), 64'(e_full));
        chk({tag, ".cnt"},  64'(r_cnt),  64'(e_cnt));
        take();
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.cmd_ready", 64'(cmd_ready), 64'(0));
        chk("rst.rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst.count",     64'(count),     64'(0));
        chk("rst.rsp_hit",   64'(rsp_hit),   64'(0));
        chk("rst.rsp_val",   64'(rsp_val),   64'(0));
        chk("rst.rsp_full",  64'(rsp_full),  64'(0));
        rst = 1'b0;
        #1;
        chk("rst.ready_after", 64'(cmd_ready), 64'(1));
        @(negedge clk);

        // Basic lookup / write / overwrite / delete
        op_chk("lk_ram0",   LOOKUP, K_RAM,   '0,       9, 0, 32'h0,  0, 0);
        op_chk("wr_ram",    WRITE,  K_RAM,   32'h40,   9, 0, 32'h0,  0, 1);
        op_chk("wr_sita",   WRITE,  K_SITA,  32'h35,   9, 0, 32'h0,  0, 2);
        op_chk("lk_ram",    LOOKUP, K_RAM,   '0,       9, 1, 32'h40, 0, 2);
        op_chk("lk_kamal",  LOOKUP, K_KAMAL, '0,       9, 0, 32'h0,  0, 2);
        op_chk("wr_ram2",   WRITE,  K_RAM,   32'h41,   9, 1, 32'h40, 0, 2);
        op_chk("lk_ram2",   LOOKUP, K_RAM,   '0,       9, 1, 32'h41, 0, 2);
        op_chk("del_sita",  DELETE, K_SITA,  '0,       9, 1, 32'h35, 0, 1);
        op_chk("del_sita2", DELETE, K_SITA,  '0,       9, 0, 32'h0,  0, 1);

        // Fill to capacity, overflow, free a slot, refill
        op_chk("clr0", CLEAR, '0, '0, 1, 0, 32'h0, 0, 0);
        for (int k = 1; k <= 8; k++)
            op_chk($sformatf("wr_k%0d", k), WRITE, KEY_W'(k), VAL_W'(32'h100 + k), 9, 0, 32'h0, 0, k);
        op_chk("wr9_full", WRITE,  40'd9, 32'h109, 9, 0, 32'h0,   1, 8);
        op_chk("del4",     DELETE, 40'd4, '0,      9, 1, 32'h104, 0, 7);
        op_chk("wr9",      WRITE,  40'd9, 32'h109, 9, 0, 32'h0,   0, 8);
        op_chk("lk9",      LOOKUP, 40'd9, '0,      9, 1, 32'h109, 0, 8);
        op_chk("lk4",      LOOKUP, 40'd4, '0,      9, 0, 32'h0,   0, 8);
        chk("slot3.valid", 64'(dut.ent_valid[3]), 64'(1));
        chk("slot3.key",   64'(dut.ent_key[3]),   64'(9));

        // Backpressure: response held, a competing command is not accepted
        rsp_ready = 1'b0;
        send(LOOKUP, 40'd9, '0);
        chk("bp.lat", 64'(r_lat), 64'(9));
        chk("bp.hit", 64'(r_hit), 64'(1));
        chk("bp.val", 64'(r_val), 64'(32'h109));
        cmd_op    = DELETE;
        cmd_key   = 40'd1;
        cmd_val   = '0;
        cmd_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("bp%0d.rsp_valid", c), 64'(rsp_valid), 64'(1));
            chk($sformatf("bp%0d.rsp_hit", c),   64'(rsp_hit),   64'(1));
            chk($sformatf("bp%0d.rsp_val", c),   64'(rsp_val),   64'(32'h109));
            chk($sformatf("bp%0d.rsp_full", c),  64'(rsp_full),  64'(0));
            chk($sformatf("bp%0d.cmd_ready", c), 64'(cmd_ready), 64'(0));
            chk($sformatf("bp%0d.count", c),     64'(count),     64'(8));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("bp.rel_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("bp.rel_cmd_ready", 64'(cmd_ready), 64'(1));
        send(DELETE, 40'd1, '0);
        chk("bp.next_wait", 64'(r_wait), 64'(0));
        chk("bp.next_lat",  64'(r_lat),  64'(9));
        chk("bp.next_hit",  64'(r_hit),  64'(1));
        chk("bp.next_val",  64'(r_val),  64'(32'h101));
        chk("bp.next_cnt",  64'(r_cnt),  64'(7));
        take();

        // Reset in the middle of a write scan aborts it and empties the table
        cmd_op    = WRITE;
        cmd_key   = 40'hAB;
        cmd_val   = 32'hCD;
        cmd_valid = 1'b1;
        #1;
        chk("abort.accept_ready", 64'(cmd_ready), 64'(1));
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort.ready_in_rst", 64'(cmd_ready), 64'(0));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort.count",     64'(count),     64'(0));
        chk("abort.rsp_valid", 64'(rsp_valid), 64'(0));
        chk("abort.cmd_ready", 64'(cmd_ready), 64'(1));
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("abort.no_rsp", 64'(seen), 64'(0));
        op_chk("abort.lk_ab", LOOKUP, 40'hAB, '0, 9, 0, 32'h0, 0, 0);
        op_chk("abort.lk_9",  LOOKUP, 40'd9,  '0, 9, 0, 32'h0, 0, 0);

        // Clear with a partially loaded table
        op_chk("ld_ram",  WRITE, K_RAM,  32'h40, 9, 0, 32'h0, 0, 1);
        op_chk("ld_sita", WRITE, K_SITA, 32'h35, 9, 0, 32'h0, 0, 2);
        op_chk("ld_7",    WRITE, 40'd7,  32'h77, 9, 0, 32'h0, 0, 3);
        op_chk("clr3",    CLEAR, K_RAM,  '0,     1, 0, 32'h0, 0, 0);
        op_chk("clr.lk_ram",  LOOKUP, K_RAM,  '0, 9, 0, 32'h0, 0, 0);
        op_chk("clr.lk_sita", LOOKUP, K_SITA, '0, 9, 0, 32'h0, 0, 0);
        op_chk("clr.lk_7",    LOOKUP, 40'd7,  '0, 9, 0, 32'h0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
